// File: rtl/uart_tick_tx.sv
// uart_tick_tx: UART transmitter paced by an external baud-rate tick.
//
// A word is accepted in IDLE and sent as one frame: a start bit (0), DATA_BITS
// data bits LSB first, an optional parity bit, then STOP_BITS stop bits (1).
// Each bit lasts one BaudTick period. Tx is driven only from a flop, so it
// changes in the cycle after each counted tick.
//
// Parameters:
//   DATA_BITS  data bits per frame, 5..9
//   PARITY     0 none, 1 even, 2 odd
//   STOP_BITS  1 or 2
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      asynchronous, active-high reset
//   BaudTick   one-cycle enable per bit period; a tick held high for several
//              cycles counts once per cycle
//   Data       word to transmit
//   Valid      Data is offered for transfer
//   Ready      the block accepts a word this cycle
//   Tx         serial line, idle high
//   Busy       a frame is accepted and not yet complete
//   dbg_state  current FSM state (0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP)
//
// Handshake: a word transfers on a rising Clk edge where Valid and Ready are
// both 1. Ready depends only on internal state, never on Valid. Once a word
// is taken, Data and Valid are ignored until the block returns to IDLE.

module uart_tick_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 BaudTick,
  input  logic [DATA_BITS-1:0] Data,
  input  logic                 Valid,
  output logic                 Ready,
  output logic                 Tx,
  output logic                 Busy,
  output logic [2:0]           dbg_state
);

  // Elaboration guard on the parameter ranges.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tick_tx: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tick_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tick_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int                 CNT_W     = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(DATA_BITS);
  localparam logic               ODD       = (PARITY == 2);
  localparam logic               HAS_PAR   = (PARITY != 0);
  localparam logic               STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state;
  state_t               state_n;
  logic                 armed;       // low from reset until the first Clk edge
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     bit_cnt;     // data bits already placed on Tx
  logic                 start_sent;  // START: start bit is on the line
  logic                 par_bit;
  logic                 stop_cnt;
  logic                 tx_q;
  logic                 accept;

  assign accept = Valid && Ready;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
    end
  end

  // Next-state logic. START covers both the wait for the first tick after
  // acceptance and the start bit itself; the tick that ends the start bit
  // puts data bit 0 on the line and enters DATA.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (accept) state_n = S_START;
      S_START:  if (BaudTick && start_sent) state_n = S_DATA;
      S_DATA:   if (BaudTick && bit_cnt == BIT_LAST)
                  state_n = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (BaudTick) state_n = S_STOP;
      S_STOP:   if (BaudTick && stop_cnt == STOP_LAST) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Datapath: shift register, counters and the Tx flop. Parity is computed
  // from the word at acceptance, since the shift register is consumed as
  // bits go out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tx_q       <= 1'b1;
      shift      <= '0;
      bit_cnt    <= '0;
      start_sent <= 1'b0;
      par_bit    <= 1'b0;
      stop_cnt   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shift      <= Data;
            par_bit    <= (^Data) ^ ODD;
            bit_cnt    <= '0;
            start_sent <= 1'b0;
            stop_cnt   <= 1'b0;
          end
        end
        S_START: begin
          if (BaudTick) begin
            if (!start_sent) begin
              tx_q       <= 1'b0;
              start_sent <= 1'b1;
            end else begin
              tx_q    <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= CNT_W'(1);
            end
          end
        end
        S_DATA: begin
          if (BaudTick) begin
            if (bit_cnt != BIT_LAST) begin
              tx_q    <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end else if (HAS_PAR) begin
              tx_q <= par_bit;
            end else begin
              tx_q     <= 1'b1;
              stop_cnt <= 1'b0;
            end
          end
        end
        S_PARITY: begin
          if (BaudTick) begin
            tx_q     <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          if (BaudTick && stop_cnt != STOP_LAST) stop_cnt <= 1'b1;
        end
        default: tx_q <= 1'b1;
      endcase
    end
  end

  // Outputs
  always_comb begin
    Ready     = armed && (state == S_IDLE);
    Busy      = (state != S_IDLE);
    Tx        = tx_q;
    dbg_state = state;
  end

endmodule
